// File: rtl/protocol_frame_tx.sv
// Serial SPI framer: SYNC | type | payload | CRC-8 | TAIL, 81 bits MSB first; first bit one cycle after accept, frame_done on frame[0].
// Backpressure: ready is low from accept through the inter-frame gap, and req is ignored while ready is low.
module protocol_frame_tx #(
    parameter logic [15:0] SYNC_WORD  = 16'hEB90,
    parameter logic [7:0]  TAIL_BYTE  = 8'h00,
    parameter logic [7:0]  CRC_POLY   = 8'h07,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        sck,
    input  logic        rst,
    input  logic [40:0] payload_in,
    input  logic [7:0]  type_in,
    input  logic        req,
    output logic        ready,
    output logic        sdo,
    output logic        sdo_en,
    output logic [80:0] frame_out,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CRC,
        S_TAIL,
        S_GAP
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 32'd1);

    state_t      state;
    logic [6:0]  bit_cnt;
    logic [7:0]  gap_cnt;
    logic [48:0] data_sr;
    logic [7:0]  crc;
    logic [7:0]  crc_next;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    assign crc_next = crc_step(crc, data_sr[48]);

    // bit_cnt holds the index, within the current field, of the bit now on sdo.
    // data_sr rotates, so after 49 DATA shifts it again holds {type, payload}.
    always_ff @(posedge sck) begin
        frame_done <= 1'b0;
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            data_sr   <= '0;
            crc       <= '0;
            ready     <= 1'b0;
            sdo       <= 1'b0;
            sdo_en    <= 1'b0;
            frame_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ready && req) begin
                        data_sr <= {type_in, payload_in};
                        crc     <= '0;
                        state   <= S_HDR;
                        bit_cnt <= 7'd15;
                        sdo     <= SYNC_WORD[15];
                        sdo_en  <= 1'b1;
                        ready   <= 1'b0;
                    end else begin
                        ready  <= 1'b1;
                        sdo    <= 1'b0;
                        sdo_en <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (bit_cnt != 7'd0) begin
                        bit_cnt <= bit_cnt - 7'd1;
                        sdo     <= SYNC_WORD[bit_cnt[3:0] - 4'd1];
                    end else begin
                        state   <= S_DATA;
                        bit_cnt <= 7'd48;
                        sdo     <= data_sr[48];
                    end
                end
                S_DATA: begin
                    crc     <= crc_next;
                    data_sr <= {data_sr[47:0], data_sr[48]};
                    if (bit_cnt != 7'd0) begin
                        bit_cnt <= bit_cnt - 7'd1;
                        sdo     <= data_sr[47];
                    end else begin
                        // The last data bit is folded in here, so the CRC MSB comes from crc_next.
                        state   <= S_CRC;
                        bit_cnt <= 7'd7;
                        sdo     <= crc_next[7];
                    end
                end
                S_CRC: begin
                    if (bit_cnt != 7'd0) begin
                        bit_cnt <= bit_cnt - 7'd1;
                        sdo     <= crc[bit_cnt[2:0] - 3'd1];
                    end else begin
                        state   <= S_TAIL;
                        bit_cnt <= 7'd7;
                        sdo     <= TAIL_BYTE[7];
                    end
                end
                S_TAIL: begin
                    if (bit_cnt != 7'd0) begin
                        bit_cnt <= bit_cnt - 7'd1;
                        sdo     <= TAIL_BYTE[bit_cnt[2:0] - 3'd1];
                        if (bit_cnt == 7'd1) begin
                            frame_done <= 1'b1;
                            frame_out  <= {SYNC_WORD, data_sr, crc, TAIL_BYTE};
                        end
                    end else begin
                        sdo    <= 1'b0;
                        sdo_en <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                            ready <= 1'b1;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LAST;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt != 8'd0) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end else begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    ready  <= 1'b0;
                    sdo    <= 1'b0;
                    sdo_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_protocol_frame_tx.sv
// Bench: two framers (gap 2 and gap 0) on shared stimulus, checked each cycle against a cycles-since-accept model.
module tb_protocol_frame_tx;

    logic        sck = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [40:0] payload = '0;
    logic [7:0]  typ = '0;
    logic        held = 1'b0;

    logic        ready_v[2];
    logic        sdo_v[2];
    logic        en_v[2];
    logic        done_v[2];
    logic [80:0] fout_v[2];

    protocol_frame_tx #(.GAP_CYCLES(2)) dut_g2 (
        .sck(sck), .rst(rst), .payload_in(payload), .type_in(typ), .req(req),
        .ready(ready_v[0]), .sdo(sdo_v[0]), .sdo_en(en_v[0]),
        .frame_out(fout_v[0]), .frame_done(done_v[0])
    );

    protocol_frame_tx #(.GAP_CYCLES(0)) dut_g0 (
        .sck(sck), .rst(rst), .payload_in(payload), .type_in(typ), .req(req),
        .ready(ready_v[1]), .sdo(sdo_v[1]), .sdo_en(en_v[1]),
        .frame_out(fout_v[1]), .frame_done(done_v[1])
    );

    always #5 sck = ~sck;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string name, input int d, input logic [80:0] got, input logic [80:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s dut%0d got=%h want=%h", name, d, got, want);
    endtask

    // CRC as the remainder of polynomial long division by x^8 + CRC_POLY.
    function automatic logic [7:0] poly_rem(input logic [56:0] v_in);
        logic [56:0] v;
        v = v_in;
        for (int i = 56; i >= 8; i--)
            if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
        return v[7:0];
    endfunction

    function automatic logic [80:0] build_frame(input logic [7:0] t, input logic [40:0] p);
        return {16'hEB90, t, p, poly_rem({t, p, 8'h00}), 8'h00};
    endfunction

    function automatic logic analyser_ok(input logic [80:0] f);
        return (poly_rem(f[64:8]) == 8'h00) && (f[80:65] == 16'hEB90) && (f[7:0] == 8'h00);
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Model: age = cycles since accept (0 = not in a frame).
    int          m_age[2] = '{0, 0};
    logic        m_rdy[2] = '{1'b0, 1'b0};
    logic [80:0] m_cur[2];
    logic [80:0] m_out[2] = '{81'b0, 81'b0};

    always @(posedge sck) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_age[d] = 0;
                m_rdy[d] = 1'b0;
                m_out[d] = '0;
            end else if (m_age[d] == 0) begin
                if (m_rdy[d] && req) begin
                    m_cur[d] = build_frame(typ, payload);
                    m_age[d] = 1;
                    m_rdy[d] = 1'b0;
                end else begin
                    m_rdy[d] = 1'b1;
                end
            end else begin
                m_age[d]++;
                if (m_age[d] == 81) m_out[d] = m_cur[d];
                if (m_age[d] == 82 + gap_of(d)) begin
                    m_age[d] = 0;
                    m_rdy[d] = 1'b1;
                end
            end
        end
    end

    logic [80:0] ser[2];
    logic [80:0] last_frame[2];
    logic        prev_en[2] = '{1'b0, 1'b0};
    logic        start_held[2] = '{1'b0, 1'b0};
    int          start_cyc[2] = '{0, 0};
    int          n_done[2] = '{0, 0};
    int          a_m;
    int          bad_m;
    logic        en_m, s_m, done_m;

    always @(negedge sck) begin
        if (cyc > 0) begin
            for (int d = 0; d < 2; d++) begin
                a_m    = m_age[d];
                en_m   = (a_m >= 1) && (a_m <= 81);
                s_m    = en_m ? m_cur[d][81 - a_m] : 1'b0;
                done_m = (a_m == 81);
                chk("outputs{ready,sdo_en,sdo,frame_done}", d,
                    81'({ready_v[d], en_v[d], sdo_v[d], done_v[d]}),
                    81'({m_rdy[d], en_m, s_m, done_m}));
                chk("frame_out", d, fout_v[d], m_out[d]);
                if (en_v[d]) ser[d] = {ser[d][79:0], sdo_v[d]};
                if (en_v[d] && !prev_en[d]) begin
                    if (held && start_held[d])
                        chk("accept_spacing", d, 81'(cyc - start_cyc[d]), 81'(82 + gap_of(d)));
                    start_cyc[d]  = cyc;
                    start_held[d] = held;
                end
                prev_en[d] = en_v[d];
                if (done_v[d]) begin
                    n_done[d]++;
                    chk("done_latency", d, 81'(cyc - start_cyc[d]), 81'd80);
                    if (en_m) chk("serial_bits", d, ser[d], m_cur[d]);
                    chk("analyser_valid", d, 81'(analyser_ok(fout_v[d])), 81'd1);
                    bad_m = 0;
                    for (int i = 8; i <= 64; i++)
                        if (analyser_ok(fout_v[d] ^ (81'd1 << i))) bad_m++;
                    chk("single_flip_detected", d, 81'(bad_m), 81'd0);
                    last_frame[d] = fout_v[d];
                end
            end
        end
    end

    initial begin
        int          w;
        int          base[2];
        logic [80:0] mf;
        logic [7:0]  rt;
        logic [40:0] rp;

        // Pin the model against hand-computed frames.
        mf = build_frame(8'h00, 41'h0);
        chk("model_zero_frame", 0, mf, {16'hEB90, 65'b0});
        mf = build_frame(8'h00, 41'h1);
        chk("model_crc_p1", 0, 81'(mf[15:8]), 81'h07);
        mf = build_frame(8'h00, 41'h2);
        chk("model_crc_p2", 0, 81'(mf[15:8]), 81'h0E);

        rst = 1'b1;
        repeat (3) @(negedge sck);
        rst = 1'b0;
        @(negedge sck);

        // Zero frame
        typ = 8'h00; payload = 41'h0; req = 1'b1;
        @(negedge sck);
        req = 1'b0;
        repeat (100) @(negedge sck);
        for (int d = 0; d < 2; d++) chk("zero_frame", d, last_frame[d], {16'hEB90, 65'b0});

        // Known CRC values
        payload = 41'h1; req = 1'b1;
        @(negedge sck);
        req = 1'b0;
        repeat (100) @(negedge sck);
        for (int d = 0; d < 2; d++) chk("crc_payload_1", d, 81'(last_frame[d][15:8]), 81'h07);
        payload = 41'h2; req = 1'b1;
        @(negedge sck);
        req = 1'b0;
        repeat (100) @(negedge sck);
        for (int d = 0; d < 2; d++) chk("crc_payload_2", d, 81'(last_frame[d][15:8]), 81'h0E);

        // req held, inputs changing every cycle
        base[0] = n_done[0]; base[1] = n_done[1];
        held = 1'b1; req = 1'b1;
        repeat (8600) begin
            typ     = 8'($urandom);
            payload = 41'({$urandom, $urandom});
            @(negedge sck);
        end
        req = 1'b0; held = 1'b0;
        repeat (200) @(negedge sck);
        for (int d = 0; d < 2; d++) chk("random_frames_ge_100", d, 81'((n_done[d] - base[d]) >= 100), 81'd1);

        // Reset while bit 40 is on the line
        typ = 8'($urandom); payload = 41'({$urandom, $urandom}); req = 1'b1;
        @(negedge sck);
        req = 1'b0;
        w = 0;
        while (m_age[0] != 41 && w < 200) begin
            @(negedge sck);
            w++;
        end
        chk("reach_bit40", 0, 81'(w < 200), 81'd1);
        base[0] = n_done[0]; base[1] = n_done[1];
        rst = 1'b1;
        @(negedge sck);
        rst = 1'b0;
        for (int d = 0; d < 2; d++)
            chk("after_rst{sdo_en,sdo,ready}", d, 81'({en_v[d], sdo_v[d], ready_v[d]}), 81'd0);
        @(negedge sck);
        for (int d = 0; d < 2; d++) chk("ready_after_rst", d, 81'(ready_v[d]), 81'd1);
        repeat (100) @(negedge sck);
        for (int d = 0; d < 2; d++) chk("no_done_aborted", d, 81'(n_done[d] - base[d]), 81'd0);
        rt = 8'($urandom); rp = 41'({$urandom, $urandom});
        typ = rt; payload = rp; req = 1'b1;
        @(negedge sck);
        req = 1'b0;
        typ = ~rt; payload = ~rp;
        repeat (100) @(negedge sck);
        mf = build_frame(rt, rp);
        for (int d = 0; d < 2; d++) chk("frame_after_rst", d, last_frame[d], mf);

        // rst and req together
        base[0] = n_done[0]; base[1] = n_done[1];
        rst = 1'b1; req = 1'b1;
        @(negedge sck);
        rst = 1'b0; req = 1'b0;
        repeat (100) @(negedge sck);
        for (int d = 0; d < 2; d++) begin
            chk("simul_frame_out_zero", d, fout_v[d], 81'd0);
            chk("simul_no_frame", d, 81'(n_done[d] - base[d]), 81'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/protocol_frame_tx.md
# protocol_frame_tx

Transmit-side framer for the SPI link. It accepts a 41-bit payload plus an 8-bit type byte, builds the 81-bit link frame, and appends a CRC-8 so that the receiving frame analyser's check passes. It then shifts the frame out serially, MSB first, one bit per `sck` cycle. A parallel copy of the finished frame is also provided for loopback against the receive path.

## Interface
Parameters:
- `SYNC_WORD`, 16'hEB90: header placed in frame[80:65].
- `TAIL_BYTE`, 8'h00: trailer placed in frame[7:0].
- `CRC_POLY`, 8'h07: CRC-8 polynomial. Init 0x00, MSB-first, no reflection, no final XOR.
- `GAP_CYCLES`, 2: idle cycles after each frame before `ready` returns. Legal range 0..255.

Ports:
- `sck` in 1: the only clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `payload_in` in 41: payload, placed in frame[56:16].
- `type_in` in 8: type byte, placed in frame[64:57].
- `req` in 1: request; a frame is accepted on a cycle with `req && ready`.
- `ready` out 1: block idle and able to accept.
- `sdo` out 1: serial data out.
- `sdo_en` out 1: high on every cycle that `sdo` carries a frame bit.
- `frame_out` out 81: complete frame including CRC; updated with `frame_done`.
- `frame_done` out 1: one-cycle pulse, coincident with the frame[0] bit cycle.

## Operation
- Frame layout, 81 bits:
  - [80:65] `SYNC_WORD`
  - [64:57] type
  - [56:16] payload
  - [15:8] CRC-8 over frame[64:16] (49 bits)
  - [7:0] `TAIL_BYTE`
- CRC property: running the CRC over frame[64:8] (57 bits) leaves remainder 0x00.
- FSM states:
  - IDLE: `ready`=1. On `req`, latch `type_in`/`payload_in` into the shift register and clear the CRC register. Go to HDR.
  - HDR: 16 cycles shifting frame[80:65]. Go to DATA.
  - DATA: 49 cycles shifting frame[64:16]. Each shifted bit also updates the CRC register serially: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? `CRC_POLY` : 0). Go to CRC.
  - CRC: 8 cycles shifting the final CRC register MSB first. Go to TAIL.
  - TAIL: 8 cycles shifting `TAIL_BYTE`. Go to GAP, or to IDLE if `GAP_CYCLES`=0.
  - GAP: `GAP_CYCLES` cycles with `sdo_en`=0, then IDLE.
- Bit counter: 7 bits, reloaded at each state entry. No wrap beyond 80 is possible.
- `req` is ignored when `ready`=0. The requester holds `req`; inputs are not sampled outside the accept cycle. Changing inputs after accept does not affect the frame in flight.
- `frame_out` is held until the next `frame_done`.

## Timing
- Reset values: `ready`=0 while `rst`=1, then 1 on the first cycle after `rst` deasserts. `sdo`=0, `sdo_en`=0, `frame_done`=0, `frame_out`=0, FSM=IDLE, CRC=0x00.
- Accept on edge T. `sdo_en`=1 with `sdo`=frame[80] in the cycle after T. Frame[0] is presented 81 cycles after T.
- `frame_done` and `frame_out` are valid in the frame[0] cycle.
- `ready` rises `GAP_CYCLES` cycles after the frame[0] cycle. If `GAP_CYCLES`=0 it rises in the cycle immediately after frame[0].
- Back-to-back: with `GAP_CYCLES`=0 and `req` held, frame spacing is 82 cycles. The accept cycle always has `sdo_en`=0.
- `sdo` is 0 whenever `sdo_en`=0.
- Reset mid-frame: the frame is abandoned and all outputs return to reset values the next cycle. No `frame_done` is issued for the aborted frame.
- `rst` and `req` asserted together: reset wins and nothing is latched.

## Test plan
- Zero frame: `type_in`=0, `payload_in`=0, pulse `req`. Required: 81 serial bits = {16'hEB90, 49'b0, 8'h00, 8'h00}; `frame_done` 81 cycles after accept; `frame_out` equals the same value.
- CRC check: `type_in`=0, `payload_in`=41'h1 gives CRC 0x07 in frame[15:8]. `payload_in`=41'h2 gives 0x0E. Feed 100 random frames through the receive-side analyser (`frame_out` + `frame_done` as data/valid). Required: every payload is reported valid, and flipping any single bit of frame[64:8] makes the check fail.
- Handshake and gap: with `GAP_CYCLES`=2, hold `req` for 300 cycles. Required: accepts spaced exactly 84 cycles apart; `ready` low from accept through 2 cycles after frame[0]. Inputs changed mid-frame do not alter the transmitted frame.
- Zero gap: with `GAP_CYCLES`=0 and `req` held. Required: 82-cycle spacing; `sdo_en`=0 only on the accept cycles.
- Reset mid-frame: assert `rst` for 1 cycle at bit 40. Required: next cycle `sdo_en`=0, `sdo`=0, `ready`=0; no `frame_done`; `ready`=1 the cycle after `rst` drops; a new request then produces a correct full frame.
- Simultaneous `rst` and `req`: Required: no frame is transmitted and `frame_out` stays 0.
